// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single data-memory port between the ALU-sourced and
//   FPU-sourced memory requests leaving the X/M boundary. The two requesters
//   are arbitrated round-robin, and the winning request is latched. The
//   latched request drives a multi-cycle req/ack memory interface. Each
//   completed or timed-out access produces a one-cycle response tagged with
//   its source and destination register.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   alu_* / fpu_*         requester sets: valid, we, addr, wdata, dst in;
//                         ready out (asserted combinationally on grant)
//   mem_req/we/addr/wdata memory request, held stable while in ACCESS
//   mem_ack, mem_rdata    one-cycle completion pulse and load data
//   rsp_valid             one-cycle completion pulse qualifying rsp_*
//   rsp_src/we/dst/data   completed access info (src 0=ALU, 1=FPU)
//   rsp_err               access aborted by timeout
//   busy                  arbiter not idle (feeds pipeline stall)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          alu_valid,
    input  logic          alu_we,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_wdata,
    input  logic [RW-1:0] alu_dst,
    output logic          alu_ready,

    input  logic          fpu_valid,
    input  logic          fpu_we,
    input  logic [AW-1:0] fpu_addr,
    input  logic [DW-1:0] fpu_wdata,
    input  logic [RW-1:0] fpu_dst,
    output logic          fpu_ready,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,

    output logic          rsp_valid,
    output logic          rsp_src,
    output logic          rsp_we,
    output logic [RW-1:0] rsp_dst,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,

    output logic          busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    // 1 = FPU wins the next conflict, 0 = ALU wins
    logic          r_ptr_fpu;
    logic [CW-1:0] r_cnt;

    // Latched request
    logic          r_src;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [RW-1:0] r_dst;

    // Response registers, held between responses
    logic          r_rsp_src;
    logic          r_rsp_we;
    logic [RW-1:0] r_rsp_dst;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;

    logic          w_grant_alu;
    logic          w_grant_fpu;
    logic          w_ack_done;
    logic          w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_alu = 1'b0;
        w_grant_fpu = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alu_valid && (!fpu_valid || !r_ptr_fpu)) begin
                    w_grant_alu = 1'b1;
                end else if (fpu_valid) begin
                    w_grant_fpu = 1'b1;
                end
                if (w_grant_alu || w_grant_fpu) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack takes precedence over a timeout in the same cycle.
                // r_cnt counts completed ACCESS cycles, so TIMEOUT-1 marks
                // the last permitted one.
                if (mem_ack) begin
                    w_ack_done = 1'b1;
                    w_next     = ST_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_fpu  <= 1'b0;
            r_cnt      <= '0;
            r_src      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dst      <= '0;
            r_rsp_src  <= 1'b0;
            r_rsp_we   <= 1'b0;
            r_rsp_dst  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_grant_alu || w_grant_fpu) begin
                r_ptr_fpu <= w_grant_alu;
                r_src     <= w_grant_fpu;
                r_we      <= w_grant_fpu ? fpu_we    : alu_we;
                r_addr    <= w_grant_fpu ? fpu_addr  : alu_addr;
                r_wdata   <= w_grant_fpu ? fpu_wdata : alu_wdata;
                r_dst     <= w_grant_fpu ? fpu_dst   : alu_dst;
            end

            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_ack_done || w_timeout) begin
                r_rsp_src  <= r_src;
                r_rsp_we   <= r_we;
                r_rsp_dst  <= r_dst;
                r_rsp_data <= (w_ack_done && !r_we) ? mem_rdata : '0;
                r_rsp_err  <= w_timeout;
            end
        end
    end

    assign alu_ready = w_grant_alu;
    assign fpu_ready = w_grant_fpu;

    // mem_req decodes straight from the state register so it drops
    // asynchronously with reset.
    assign mem_req   = (r_state == ST_ACCESS);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_src   = r_rsp_src;
    assign rsp_we    = r_rsp_we;
    assign rsp_dst   = r_rsp_dst;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    assign busy      = (r_state != ST_IDLE);

endmodule
